hf_compression: RTL and testbench
=================================

Name: hf_compression

Overview:
- Huffman encoder; the transmit end of the hf_decompression bitstream.
- Accepts 4-bit symbols over a valid/ready handshake, looks each up in a 16-entry code table, and emits the code serially, one bit per clock.
- Bits go out MSB-first, so the decoder can shift them into the LSB of its code register.
- The code table is written by the host before or between encoding bursts.

Parameters:
- MAX_LEN, 16, maximum code length in bits; also the width of a table code entry.
- LEN_W, 5, width of the length field; must hold MAX_LEN.

Ports:
- CLK  in  1  clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- tbl_wr_en  in  1  table write strobe.
- tbl_wr_sym  in  4  table index (symbol value) to write.
- tbl_wr_code  in  MAX_LEN  code, right-aligned (LSB = last bit sent).
- tbl_wr_len  in  LEN_W  code length; 0 = symbol unmapped.
- sym_in  in  4  symbol to encode.
- sym_in_valid  in  1  sym_in is valid.
- sym_in_ready  out  1  encoder can accept a symbol this cycle.
- hf_out  out  1  serial code bit.
- hf_out_valid  out  1  hf_out carries a valid bit this cycle.
- sym_unmapped  out  1  one-cycle pulse: the accepted symbol had length 0.

Behaviour:
- Reset (synchronous, active-high) sets:
  - all table lengths and codes to 0;
  - hf_out = 0, hf_out_valid = 0, sym_unmapped = 0;
  - remaining-bit count = 0, state = IDLE.
- Reset asserted mid-code aborts the code immediately; no further bits are emitted.
- Registered state:
  - state: IDLE or SHIFT;
  - shreg: MAX_LEN bits, left-aligned pending bits;
  - rem: LEN_W bits, bits still to send after the current hf_out.
- sym_in_ready is a combinational function of registers only: high when state == IDLE, or when state == SHIFT and rem == 0 (the current bit is the last). There is no combinational path from any input.
- A symbol is accepted when sym_in_valid && sym_in_ready. Let L = table len[sym_in], clamped to MAX_LEN if larger.
  - L >= 1: on that edge, hf_out <= code[L-1], hf_out_valid <= 1, shreg <= code << (MAX_LEN-L+1), rem <= L-1, state <= SHIFT.
  - L == 0: no bits are emitted. sym_unmapped <= 1 for one cycle, hf_out_valid <= 0, state <= IDLE.
- Latency: the first code bit appears on hf_out in the cycle after acceptance.
- In SHIFT with rem > 0: each edge sets hf_out <= shreg[MAX_LEN-1], shreg <<= 1, rem <= rem-1.
- In SHIFT with rem == 0:
  - if a new symbol is accepted, it loads as above, giving gap-free back-to-back codes;
  - otherwise hf_out_valid <= 0, hf_out <= 0, state <= IDLE.
- While hf_out_valid == 0, hf_out is driven 0.
- Throughput: L cycles per symbol; continuous when sym_in_valid stays high.
- Table writes:
  - performed only when state == IDLE; ignored silently in SHIFT;
  - tbl_wr_len values above MAX_LEN are stored as written and clamped at lookup.
- Simultaneous table write and symbol accept in IDLE: the symbol uses the table contents from before the write; the write takes effect at that edge.
- Code bits above bit L-1 of a table entry are don't-care and are never emitted.

Optional Feature:
- Macro: HF_STATS_EN.
- When defined, two extra outputs are added:
  - sym_count[31:0]: increments on each accepted symbol with L >= 1;
  - bit_count[31:0]: increments each cycle hf_out_valid == 1.
- Both counters reset to 0 on Reset and wrap at 2^32.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hf_pkg holds:
  - constants HF_SYM_W = 4, HF_NUM_SYM = 16, HF_MAX_LEN = 16, HF_LEN_W = 5;
  - a state enum {HF_IDLE, HF_SHIFT};
  - typedef hf_entry_t {code[HF_MAX_LEN], len[HF_LEN_W]}.
- The package is shared with hf_decompression.
- One sub-module is natural: hf_code_table, the 16-entry register file with a write port and a combinational read port.
- Serializer and handshake logic stay in the top level.

Test Plan:
- Load sym 0x3 = code 0b101, len 3; send sym 0x3 -> hf_out 1,0,1 with hf_out_valid on the 3 cycles after acceptance; sym_in_ready low on the first 2 of those cycles, high on the 3rd.
- Load 0x0 = 0b0 (len 1) and 0x1 = 0b11 (len 2); stream 0x0,0x1,0x0 with valid held high -> bits 0,1,1,0 on 4 consecutive cycles with no gap; then hf_out_valid = 0.
- Load 0xF = 0xFFFF, len 16 -> 16 consecutive 1 bits; tbl_wr_len 20 behaves identically (clamped).
- Send an unloaded symbol 0x7 (len 0) -> sym_unmapped pulses one cycle; no hf_out_valid; ready remains high.
- Issue a table write to 0x3 during SHIFT -> write is ignored and the next 0x3 still emits 101. Issue a write plus an accept of 0x3 together in IDLE -> old code is emitted, the new code applies to the following 0x3.
- Assert Reset at bit 2 of a 5-bit code -> hf_out_valid = 0 the next cycle and the table reads len 0. With HF_STATS_EN, after test 2 sym_count = 3 and bit_count = 4.

Source files
------------

// File: rtl/hf_pkg.sv
// Shared Huffman definitions used by hf_compression and hf_decompression.
package hf_pkg;
  localparam int HF_SYM_W   = 4;
  localparam int HF_NUM_SYM = 16;
  localparam int HF_MAX_LEN = 16;
  localparam int HF_LEN_W   = 5;

  typedef enum logic [0:0] {
    HF_IDLE  = 1'b0,
    HF_SHIFT = 1'b1
  } hf_state_e;

  typedef struct packed {
    logic [HF_MAX_LEN-1:0] code;
    logic [HF_LEN_W-1:0]   len;
  } hf_entry_t;
endpackage

// File: rtl/hf_code_table.sv
// 16-entry Huffman code table.
// It has one synchronous write port and a combinational read port, and it is cleared on reset.
module hf_code_table
  import hf_pkg::*;
#(
  parameter int MAX_LEN = HF_MAX_LEN,
  parameter int LEN_W   = HF_LEN_W
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                wr_en,
  input  logic [HF_SYM_W-1:0] wr_sym,
  input  logic [MAX_LEN-1:0]  wr_code,
  input  logic [LEN_W-1:0]    wr_len,
  input  logic [HF_SYM_W-1:0] rd_sym,
  output logic [MAX_LEN-1:0]  rd_code,
  output logic [LEN_W-1:0]    rd_len
);
  logic [MAX_LEN-1:0] code_reg [HF_NUM_SYM];
  logic [LEN_W-1:0]   len_reg  [HF_NUM_SYM];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < HF_NUM_SYM; i++) begin
        code_reg[i] <= '0;
        len_reg[i]  <= '0;
      end
    end else if (wr_en) begin
      code_reg[wr_sym] <= wr_code;
      len_reg[wr_sym]  <= wr_len;
    end
  end

  assign rd_code = code_reg[rd_sym];
  assign rd_len  = len_reg[rd_sym];
endmodule

// File: rtl/hf_compression.sv
// Huffman encoder. It serializes table codes MSB-first, one bit per clock, and consecutive codes follow each other without gaps.
// Optional HF_STATS_EN adds the sym_count and bit_count statistics outputs.
module hf_compression
  import hf_pkg::*;
#(
  parameter int MAX_LEN = HF_MAX_LEN,
  parameter int LEN_W   = HF_LEN_W
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                tbl_wr_en,
  input  logic [HF_SYM_W-1:0] tbl_wr_sym,
  input  logic [MAX_LEN-1:0]  tbl_wr_code,
  input  logic [LEN_W-1:0]    tbl_wr_len,
  input  logic [HF_SYM_W-1:0] sym_in,
  input  logic                sym_in_valid,
  output logic                sym_in_ready,
  output logic                hf_out,
  output logic                hf_out_valid,
  output logic                sym_unmapped
`ifdef HF_STATS_EN
  ,
  output logic [31:0]         sym_count,
  output logic [31:0]         bit_count
`endif
);
  localparam logic [0:0] ST_IDLE  = HF_IDLE;
  localparam logic [0:0] ST_SHIFT = HF_SHIFT;
  localparam int IDX_W = $clog2(MAX_LEN);

  logic [0:0]         state_reg;
  logic [MAX_LEN-1:0] shreg_reg;
  logic [LEN_W-1:0]   rem_reg;
  logic               hf_out_reg, hf_out_valid_reg, sym_unmapped_reg;

  logic [MAX_LEN-1:0] rd_code;
  logic [LEN_W-1:0]   rd_len, len_clamped, len_m1, shift_amt;
  logic               accept, first_bit;
  logic [IDX_W-1:0]   first_idx;

  // Lookup uses pre-write contents, so a write and an accept on the same edge behave correctly.
  hf_code_table #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_table (
    .CLK     (CLK),
    .Reset   (Reset),
    .wr_en   (tbl_wr_en && (state_reg == ST_IDLE)),
    .wr_sym  (tbl_wr_sym),
    .wr_code (tbl_wr_code),
    .wr_len  (tbl_wr_len),
    .rd_sym  (sym_in),
    .rd_code (rd_code),
    .rd_len  (rd_len)
  );

  assign sym_in_ready = (state_reg == ST_IDLE) ||
                        ((state_reg == ST_SHIFT) && (rem_reg == '0));
  assign accept       = sym_in_valid && sym_in_ready;

  assign len_clamped = (rd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : rd_len;
  assign len_m1      = len_clamped - LEN_W'(1);
  assign first_idx   = len_m1[IDX_W-1:0];
  assign first_bit   = rd_code[first_idx];
  assign shift_amt   = LEN_W'(MAX_LEN) - len_clamped + LEN_W'(1);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg        <= ST_IDLE;
      shreg_reg        <= '0;
      rem_reg          <= '0;
      hf_out_reg       <= 1'b0;
      hf_out_valid_reg <= 1'b0;
      sym_unmapped_reg <= 1'b0;
    end else begin
      sym_unmapped_reg <= 1'b0;
      if (accept) begin
        if (len_clamped != '0) begin
          hf_out_reg       <= first_bit;
          hf_out_valid_reg <= 1'b1;
          shreg_reg        <= rd_code << shift_amt;
          rem_reg          <= len_m1;
          state_reg        <= ST_SHIFT;
        end else begin
          sym_unmapped_reg <= 1'b1;
          hf_out_reg       <= 1'b0;
          hf_out_valid_reg <= 1'b0;
          rem_reg          <= '0;
          state_reg        <= ST_IDLE;
        end
      end else if ((state_reg == ST_SHIFT) && (rem_reg != '0)) begin
        hf_out_reg <= shreg_reg[MAX_LEN-1];
        shreg_reg  <= shreg_reg << 1;
        rem_reg    <= rem_reg - LEN_W'(1);
      end else begin
        hf_out_reg       <= 1'b0;
        hf_out_valid_reg <= 1'b0;
        state_reg        <= ST_IDLE;
      end
    end
  end

  assign hf_out       = hf_out_reg;
  assign hf_out_valid = hf_out_valid_reg;
  assign sym_unmapped = sym_unmapped_reg;

`ifdef HF_STATS_EN
  logic [31:0] sym_count_reg, bit_count_reg;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      sym_count_reg <= '0;
      bit_count_reg <= '0;
    end else begin
      if (accept && (len_clamped != '0)) sym_count_reg <= sym_count_reg + 32'd1;
      if (hf_out_valid_reg)              bit_count_reg <= bit_count_reg + 32'd1;
    end
  end

  assign sym_count = sym_count_reg;
  assign bit_count = bit_count_reg;
`endif
endmodule

// File: tb/tb_hf_compression.sv
// Directed self-checking bench for hf_compression (stats checked when HF_STATS_EN is defined).
module tb_hf_compression;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        tbl_wr_en;
  logic [3:0]  tbl_wr_sym;
  logic [15:0] tbl_wr_code;
  logic [4:0]  tbl_wr_len;
  logic [3:0]  sym_in;
  logic        sym_in_valid;
  logic        sym_in_ready, hf_out, hf_out_valid, sym_unmapped;
`ifdef HF_STATS_EN
  logic [31:0] sym_count, bit_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  hf_compression dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .tbl_wr_en    (tbl_wr_en),
    .tbl_wr_sym   (tbl_wr_sym),
    .tbl_wr_code  (tbl_wr_code),
    .tbl_wr_len   (tbl_wr_len),
    .sym_in       (sym_in),
    .sym_in_valid (sym_in_valid),
    .sym_in_ready (sym_in_ready),
    .hf_out       (hf_out),
    .hf_out_valid (hf_out_valid),
    .sym_unmapped (sym_unmapped)
`ifdef HF_STATS_EN
    ,
    .sym_count    (sym_count),
    .bit_count    (bit_count)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] s, input logic [15:0] c, input logic [4:0] l);
    tbl_wr_en = 1'b1; tbl_wr_sym = s; tbl_wr_code = c; tbl_wr_len = l;
    step();
    tbl_wr_en = 1'b0;
  endtask

  // Checks len bits MSB-first starting at the current cycle, then the idle cycle after them.
  task automatic expect_bits(input string tag, input int len, input logic [15:0] code);
    for (int i = 0; i < len; i++) begin
      chk({tag, "_valid"}, 32'(hf_out_valid), 32'd1);
      chk({tag, "_bit"}, 32'(hf_out), 32'(code[len-1-i]));
      chk({tag, "_ready"}, 32'(sym_in_ready), (i == len-1) ? 32'd1 : 32'd0);
      $display("%s bit %0d: hf_out=%0b ready=%0b", tag, i, hf_out, sym_in_ready);
      step();
    end
    chk({tag, "_end_valid"}, 32'(hf_out_valid), 32'd0);
    chk({tag, "_end_out"}, 32'(hf_out), 32'd0);
  endtask

  task automatic send_check(input string tag, input logic [3:0] s, input int len, input logic [15:0] code);
    sym_in = s; sym_in_valid = 1'b1;
    step();
    sym_in_valid = 1'b0;
    expect_bits(tag, len, code);
  endtask

  initial begin
    Reset = 1'b1; tbl_wr_en = 1'b0; tbl_wr_sym = '0; tbl_wr_code = '0; tbl_wr_len = '0;
    sym_in = '0; sym_in_valid = 1'b0;
    step(); step();
    chk("rst_valid", 32'(hf_out_valid), 32'd0);
    chk("rst_out", 32'(hf_out), 32'd0);
    chk("rst_unmapped", 32'(sym_unmapped), 32'd0);
    chk("rst_ready", 32'(sym_in_ready), 32'd1);
    Reset = 1'b0;
    step();

    // Basic 3-bit code 101.
    wr(4'h3, 16'b101, 5'd3);
    send_check("t1_sym3", 4'h3, 3, 16'b101);

    // Back-to-back stream 0,1,0 starting from a fresh reset.
    Reset = 1'b1; step(); Reset = 1'b0;
    wr(4'h0, 16'b0, 5'd1);
    wr(4'h1, 16'b11, 5'd2);
    sym_in = 4'h0; sym_in_valid = 1'b1;
    step();
    sym_in = 4'h1;
    chk("t2_b0", 32'(hf_out), 32'd0); chk("t2_v0", 32'(hf_out_valid), 32'd1);
    chk("t2_r0", 32'(sym_in_ready), 32'd1);
    step();
    sym_in = 4'h0;
    chk("t2_b1", 32'(hf_out), 32'd1); chk("t2_v1", 32'(hf_out_valid), 32'd1);
    chk("t2_r1", 32'(sym_in_ready), 32'd0);
    step();
    chk("t2_b2", 32'(hf_out), 32'd1); chk("t2_v2", 32'(hf_out_valid), 32'd1);
    chk("t2_r2", 32'(sym_in_ready), 32'd1);
    step();
    sym_in_valid = 1'b0;
    chk("t2_b3", 32'(hf_out), 32'd0); chk("t2_v3", 32'(hf_out_valid), 32'd1);
    step();
    chk("t2_end_valid", 32'(hf_out_valid), 32'd0);
    $display("t2 stream 0,1,0 done");
`ifdef HF_STATS_EN
    chk("t2_sym_count", sym_count, 32'd3);
    chk("t2_bit_count", bit_count, 32'd4);
`endif

    // 16-bit codes, then a stored length of 20 clamped to 16.
    wr(4'hF, 16'hFFFF, 5'd16);
    send_check("t3_len16", 4'hF, 16, 16'hFFFF);
    wr(4'hF, 16'h8001, 5'd20);
    send_check("t3_len20", 4'hF, 16, 16'h8001);

    // Unmapped symbol.
    sym_in = 4'h7; sym_in_valid = 1'b1;
    step();
    sym_in_valid = 1'b0;
    chk("t4_unmapped", 32'(sym_unmapped), 32'd1);
    chk("t4_valid", 32'(hf_out_valid), 32'd0);
    chk("t4_ready", 32'(sym_in_ready), 32'd1);
    step();
    chk("t4_unmapped_clr", 32'(sym_unmapped), 32'd0);
    chk("t4_valid2", 32'(hf_out_valid), 32'd0);
    $display("t4 unmapped sym 7 done");

    // A write during SHIFT is ignored.
    wr(4'h3, 16'b101, 5'd3);
    sym_in = 4'h3; sym_in_valid = 1'b1;
    step();
    sym_in_valid = 1'b0;
    chk("t5_b0", 32'(hf_out), 32'd1);
    tbl_wr_en = 1'b1; tbl_wr_sym = 4'h3; tbl_wr_code = 16'b010; tbl_wr_len = 5'd3;
    step();
    tbl_wr_en = 1'b0;
    chk("t5_b1", 32'(hf_out), 32'd0);
    step();
    chk("t5_b2", 32'(hf_out), 32'd1);
    step();
    send_check("t5_after_shift_wr", 4'h3, 3, 16'b101);

    // A write and an accept on the same IDLE edge: the old code is sent first.
    tbl_wr_en = 1'b1; tbl_wr_sym = 4'h3; tbl_wr_code = 16'b0110; tbl_wr_len = 5'd4;
    sym_in = 4'h3; sym_in_valid = 1'b1;
    step();
    tbl_wr_en = 1'b0; sym_in_valid = 1'b0;
    expect_bits("t5_old_code", 3, 16'b101);
    send_check("t5_new_code", 4'h3, 4, 16'b0110);

    // Reset in the middle of a 5-bit code.
    wr(4'h5, 16'b10110, 5'd5);
    sym_in = 4'h5; sym_in_valid = 1'b1;
    step();
    sym_in_valid = 1'b0;
    chk("t6_b0", 32'(hf_out), 32'd1);
    step();
    chk("t6_b1", 32'(hf_out), 32'd0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("t6_rst_valid", 32'(hf_out_valid), 32'd0);
    chk("t6_rst_out", 32'(hf_out), 32'd0);
    step();
    chk("t6_idle_valid", 32'(hf_out_valid), 32'd0);
    sym_in = 4'h5; sym_in_valid = 1'b1;
    step();
    sym_in_valid = 1'b0;
    chk("t6_tbl_cleared", 32'(sym_unmapped), 32'd1);
    chk("t6_no_bits", 32'(hf_out_valid), 32'd0);
    $display("t6 mid-code reset done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
